// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the execute stage and its neighbours.
//   op_t         : 3-bit operation encoding presented by the issuer
//   exec_state_t : top-level execute FSM states
//   R0..R7       : register-file addresses (R0 is hard-wired, never written)
//   WIDTH_DEF / AW_DEF : default datapath and register-address widths
package cpu_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int AW_DEF    = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_WB   = 2'd2
    } exec_state_t;

    localparam logic [2:0] R0 = 3'd0;
    localparam logic [2:0] R1 = 3'd1;
    localparam logic [2:0] R2 = 3'd2;
    localparam logic [2:0] R3 = 3'd3;
    localparam logic [2:0] R4 = 3'd4;
    localparam logic [2:0] R5 = 3'd5;
    localparam logic [2:0] R6 = 3'd6;
    localparam logic [2:0] R7 = 3'd7;

endpackage

// File: rtl/exec_stage_if.sv
// Issue / write-back bundle between the issuer, the execute stage and the
// register file.
//   master : issuer side  - drives in_valid/op/a/b/dst/we_req, observes the rest
//   slave  : execute side - accepts the operation, drives in_ready, wb_*, flags, busy
interface exec_stage_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
);
    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [AW-1:0]    dst;
    logic             we_req;
    logic             wb_we;
    logic [AW-1:0]    wb_reg;
    logic [WIDTH-1:0] wb_data;
    logic             flag_z;
    logic             flag_c;
    logic             busy;

    modport master (
        output in_valid, op, a, b, dst, we_req,
        input  in_ready, wb_we, wb_reg, wb_data, flag_z, flag_c, busy
    );

    modport slave (
        input  in_valid, op, a, b, dst, we_req,
        output in_ready, wb_we, wb_reg, wb_data, flag_z, flag_c, busy
    );
endinterface

// File: rtl/exec_stage_seq_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per clock.
//   start   : load operands and begin (ignored while busy)
//   a, b    : multiplicand, multiplier
//   busy    : high from the start edge until the final iteration edge
//   done    : combinational pulse during the last iteration cycle; product is
//             valid in that same cycle so the caller can register it on the
//             edge that finishes the iteration
//   product : full 2*WIDTH result
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]      cnt;
    logic               busy_r;
    logic [2*WIDTH-1:0] mcand_p0;
    logic [WIDTH-1:0]   mplier_p0;
    logic [2*WIDTH-1:0] acc_p1;
    logic [2*WIDTH-1:0] term;
    logic [2*WIDTH-1:0] sum_nxt;

    always_comb begin
        term    = mplier_p0[cnt] ? (mcand_p0 << cnt) : '0;
        sum_nxt = acc_p1 + term;
    end

    assign busy    = busy_r;
    assign done    = busy_r && (cnt == LAST);
    // Exposes the accumulator including the current iteration's partial
    // product, so the final sum is available before it is stored.
    assign product = sum_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            cnt    <= '0;
        end else if (start && !busy_r) begin
            busy_r <= 1'b1;
            cnt    <= '0;
        end else if (busy_r) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy_r <= 1'b0;
            end
        end
    end

    // Operand and accumulator storage: qualified by start/busy, no reset needed.
    always_ff @(posedge clk) begin
        if (start && !busy_r) begin
            mcand_p0  <= {{WIDTH{1'b0}}, a};
            mplier_p0 <= b;
            acc_p1    <= '0;
        end else if (busy_r) begin
            acc_p1 <= sum_nxt;
        end
    end
endmodule

// File: rtl/exec_stage.sv
// Execute stage between register-file read and write-back.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : exec_stage_if.slave - issue handshake (in_valid/in_ready, op,
//              a, b, dst, we_req) and write-back/flags (wb_we, wb_reg,
//              wb_data, flag_z, flag_c, busy)
// Single-cycle ALU ops register their result on the accepting edge; MUL runs
// an 8-iteration shift-add sequence with in_ready low until write-back.
module exec_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic         clk,
    input  logic         rst,
    exec_stage_if.slave  bus
);
    exec_state_t        state;
    exec_state_t        state_nxt;
    logic               ready;
    logic               xfer;
    logic               is_mul;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [AW-1:0]      mul_dst_p0;
    logic               mul_we_p0;
    logic [WIDTH:0]     alu_res;
    logic               wb_we_r;
    logic [AW-1:0]      wb_reg_r;
    logic [WIDTH-1:0]   wb_data_r;
    logic               flag_z_r;
    logic               flag_c_r;

    // Returns {carry, result}. MUL is not handled here.
    function automatic logic [WIDTH:0] alu_eval(
        input op_t              f_op,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH:0] wide;
        logic [2:0]     sh;
        sh = y[2:0];
        case (f_op)
            OP_ADD: wide = {1'b0, x} + {1'b0, y};
            OP_SUB: wide = {(x < y), x - y};
            OP_AND: wide = {1'b0, x & y};
            OP_OR:  wide = {1'b0, x | y};
            OP_XOR: wide = {1'b0, x ^ y};
            // Bit WIDTH collects the last bit shifted out (0 when sh==0).
            OP_SHL: wide = {1'b0, x} << sh;
            // Shift through a guard bit at the bottom, then rotate it to the top.
            OP_SHR: begin
                wide = {x, 1'b0} >> sh;
                wide = {wide[0], wide[WIDTH:1]};
            end
            default: wide = '0;
        endcase
        return wide;
    endfunction

    assign is_mul    = (bus.op == OP_MUL);
    assign xfer      = bus.in_valid && ready;
    assign mul_start = xfer && is_mul;
    assign alu_res   = alu_eval(bus.op, bus.a, bus.b);

    seq_multiplier #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_WB: begin
                if (xfer) begin
                    state_nxt = is_mul ? ST_MUL : ST_WB;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_WB;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        ready    = (state != ST_MUL);
        bus.busy = mul_busy;
    end

    assign bus.in_ready = ready;

    // Destination of an in-flight MUL; only meaningful while it runs.
    always_ff @(posedge clk) begin
        if (mul_start) begin
            mul_dst_p0 <= bus.dst;
            mul_we_p0  <= bus.we_req;
        end
    end

    // Write-back and flag registers: updated only when a result completes;
    // wb_we is a one-cycle pulse, wb_reg/wb_data/flags hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we_r   <= 1'b0;
            wb_reg_r  <= '0;
            wb_data_r <= '0;
            flag_z_r  <= 1'b0;
            flag_c_r  <= 1'b0;
        end else begin
            wb_we_r <= 1'b0;
            if (mul_done) begin
                wb_we_r   <= mul_we_p0 && (mul_dst_p0 != AW'(R0));
                wb_reg_r  <= mul_dst_p0;
                wb_data_r <= mul_product[WIDTH-1:0];
                flag_z_r  <= (mul_product[WIDTH-1:0] == '0);
                flag_c_r  <= |mul_product[2*WIDTH-1:WIDTH];
            end else if (xfer && !is_mul) begin
                wb_we_r   <= bus.we_req && (bus.dst != AW'(R0));
                wb_reg_r  <= bus.dst;
                wb_data_r <= alu_res[WIDTH-1:0];
                flag_z_r  <= (alu_res[WIDTH-1:0] == '0);
                flag_c_r  <= alu_res[WIDTH];
            end
        end
    end

    assign bus.wb_we   = wb_we_r;
    assign bus.wb_reg  = wb_reg_r;
    assign bus.wb_data = wb_data_r;
    assign bus.flag_z  = flag_z_r;
    assign bus.flag_c  = flag_c_r;
endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model of the execute stage.
module tb_exec_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exec_stage_if #(.WIDTH(8), .AW(3)) bus ();

    exec_stage #(.WIDTH(8), .AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: outputs the stage must present, plus the pending MUL.
    int m_left;
    bit m_we;
    int m_reg;
    int m_data;
    bit m_z;
    bit m_c;
    int pa, pb, pdst;
    bit pwe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0; m_we = 0; m_reg = 0; m_data = 0; m_z = 0; m_c = 0;
    endtask

    task automatic set_result(input int r, input bit c, input int d, input bit we);
        m_data = r & 255;
        m_z    = (m_data == 0);
        m_c    = c;
        m_reg  = d;
        m_we   = we && (d != 0);
    endtask

    // One rising edge of the stage, from the inputs the bench presented.
    task automatic model_step();
        int v, op, a, b, d, sh, r, p;
        bit we, c;
        v  = int'(bus.in_valid);
        op = int'(bus.op);
        a  = int'(bus.a);
        b  = int'(bus.b);
        d  = int'(bus.dst);
        we = bus.we_req;
        m_we = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                p = pa * pb;
                set_result(p, p > 255, pdst, pwe);
            end
        end else if (v != 0) begin
            if (op == 7) begin
                pa = a; pb = b; pdst = d; pwe = we;
                m_left = 8;
            end else begin
                sh = b % 8;
                c  = 0;
                case (op)
                    0: begin r = a + b; c = (r > 255); end
                    1: begin r = a - b; c = (a < b); end
                    2: r = a & b;
                    3: r = a | b;
                    4: r = a ^ b;
                    5: begin r = a << sh; c = (sh != 0) && (((a >> (8 - sh)) & 1) != 0); end
                    default: begin r = a >> sh; c = (sh != 0) && (((a >> (sh - 1)) & 1) != 0); end
                endcase
                set_result(r, c, d, we);
            end
        end
    endtask

    task automatic check_outputs();
        check("wb_we",    bus.wb_we,    m_we);
        check("wb_reg",   bus.wb_reg,   m_reg);
        check("wb_data",  bus.wb_data,  m_data);
        check("flag_z",   bus.flag_z,   m_z);
        check("flag_c",   bus.flag_c,   m_c);
        check("busy",     bus.busy,     (m_left > 0));
        check("in_ready", bus.in_ready, (m_left == 0));
    endtask

    task automatic drv(input bit v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] d, input bit we);
        bus.in_valid = v;
        bus.op       = op_t'(op);
        bus.a        = a;
        bus.b        = b;
        bus.dst      = d;
        bus.we_req   = we;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic async_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
    endtask

    function automatic logic [7:0] pick_operand();
        logic [7:0] edges [4];
        edges[0] = 8'd0; edges[1] = 8'd255; edges[2] = 8'd1; edges[3] = 8'd128;
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 3)];
        return 8'($urandom_range(0, 255));
    endfunction

    initial begin
        drv(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        check("rst_ready", bus.in_ready, 1);
        check("rst_data",  bus.wb_data,  0);
        rst = 1'b0;

        // ADD 200+100 -> 44 with carry
        drv(1, 0, 200, 100, 3, 1);
        tick();
        check("add_we",   bus.wb_we,   1);
        check("add_reg",  bus.wb_reg,  3);
        check("add_data", bus.wb_data, 44);
        check("add_c",    bus.flag_c,  1);
        check("add_z",    bus.flag_z,  0);

        // SUB then XOR back-to-back
        drv(1, 1, 5, 5, 2, 1);
        tick();
        check("sub_data",  bus.wb_data,  0);
        check("sub_z",     bus.flag_z,   1);
        check("sub_c",     bus.flag_c,   0);
        check("sub_ready", bus.in_ready, 1);
        drv(1, 4, 8'hF0, 8'h0F, 4, 1);
        tick();
        check("xor_we",    bus.wb_we,    1);
        check("xor_data",  bus.wb_data,  8'hFF);
        check("xor_z",     bus.flag_z,   0);
        check("xor_ready", bus.in_ready, 1);

        // MUL 13*11 with a held ADD request behind it
        drv(1, 7, 13, 11, 5, 1);
        tick();
        drv(1, 0, 1, 2, 6, 1);
        for (int i = 0; i < 7; i++) begin
            check("mul_busy",  bus.busy,     1);
            check("mul_nordy", bus.in_ready, 0);
            tick();
        end
        check("mul_busy8", bus.busy, 1);
        tick();
        check("mul_we",    bus.wb_we,    1);
        check("mul_reg",   bus.wb_reg,   5);
        check("mul_data",  bus.wb_data,  143);
        check("mul_c",     bus.flag_c,   0);
        check("mul_ready", bus.in_ready, 1);
        check("mul_idle",  bus.busy,     0);
        tick();
        check("held_reg",  bus.wb_reg,  6);
        check("held_data", bus.wb_data, 3);

        // MUL 16*16 overflows to zero
        drv(1, 7, 16, 16, 1, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        repeat (8) tick();
        check("mul256_data", bus.wb_data, 0);
        check("mul256_z",    bus.flag_z,  1);
        check("mul256_c",    bus.flag_c,  1);

        // SHL 0x81 by 1
        drv(1, 5, 8'h81, 1, 7, 1);
        tick();
        check("shl_data", bus.wb_data, 8'h02);
        check("shl_c",    bus.flag_c,  1);

        // ADD into R0: no write, flags still update
        drv(1, 0, 1, 1, 0, 1);
        tick();
        check("r0_we",   bus.wb_we,   0);
        check("r0_data", bus.wb_data, 2);
        check("r0_c",    bus.flag_c,  0);

        // Reset at MUL iteration 4
        drv(1, 7, 200, 200, 3, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        async_reset();
        check("rstmul_ready", bus.in_ready, 1);
        check("rstmul_c",     bus.flag_c,   0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rstmul_nowe", bus.wb_we, 0);
        end

        // Reset during WB kills the write pulse immediately
        drv(1, 3, 8'h0C, 8'h30, 2, 1);
        tick();
        check("wbrst_pre", bus.wb_we, 1);
        async_reset();
        check("wbrst_we", bus.wb_we, 0);
        drv(0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        // Randomized traffic with occasional resets
        for (int n = 0; n < 2000; n++) begin
            drv($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), pick_operand(),
                pick_operand(), 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
